// File: rtl/st_acc_lvl2.sv
// Level-2 group accumulator: sums level-1 partial sums (FP4 or shifted magnitude)
// into a signed ACC_W accumulator and holds the group result until it is taken.
module st_acc_lvl2 #(
  parameter int ACC_W     = 40,
  parameter int MAX_SHIFT = 21,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_mant,
  input  logic [5:0]       in_exp,
  input  logic             in_sign,
  input  logic             in_last,
  input  logic [1:0]       prec_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       out_mode,
  output logic             out_ovf,
  output logic             out_clip
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_FP4 = 2'b11;

  state_t             state_r, state_nx;
  logic [ACC_W-1:0]   acc_r, acc_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic               ovf_r, ovf_nx;
  logic               clip_r, clip_nx;
  logic [1:0]         mode_r, mode_nx;
  logic               out_valid_r;
  logic               in_ready_r;

  logic [1:0]         beat_mode_s;
  logic [5:0]         shift_s;
  logic               clip_s;
  logic [ACC_W-1:0]   mag_s;
  logic [ACC_W-1:0]   operand_s;
  logic [ACC_W-1:0]   sum_s;
  logic               add_ovf_s;

  // Decode the incoming beat into a signed ACC_W operand and its clip condition.
  always_comb begin
    beat_mode_s = prec_mode;
    shift_s     = 6'd0;
    clip_s      = 1'b0;
    mag_s       = {ACC_W{1'b0}};
    operand_s   = {ACC_W{1'b0}};
    // The first beat of a group uses the live mode; later beats use the latched one.
    if (state_r == ST_IDLE) begin
      beat_mode_s = prec_mode;
    end else begin
      beat_mode_s = mode_r;
    end
    if (beat_mode_s == MODE_FP4) begin
      operand_s = {{(ACC_W-11){in_sign}}, in_sign, in_mant};
    end else begin
      if (in_exp > 6'(MAX_SHIFT)) begin
        shift_s = 6'(MAX_SHIFT);
        clip_s  = 1'b1;
      end else begin
        shift_s = in_exp;
        clip_s  = 1'b0;
      end
      mag_s = {{(ACC_W-10){1'b0}}, in_mant} << shift_s;
      if (in_sign) begin
        operand_s = -mag_s;
      end else begin
        operand_s = mag_s;
      end
    end
  end

  // Wrapping add with signed-overflow detection.
  always_comb begin
    sum_s     = acc_r + operand_s;
    add_ovf_s = (acc_r[ACC_W-1] == operand_s[ACC_W-1]) &&
                (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
  end

  // Next-state and next-datapath logic for the group FSM.
  always_comb begin
    state_nx = state_r;
    acc_nx   = acc_r;
    cnt_nx   = cnt_r;
    ovf_nx   = ovf_r;
    clip_nx  = clip_r;
    mode_nx  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          acc_nx   = operand_s;
          cnt_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
          ovf_nx   = 1'b0;
          clip_nx  = clip_s;
          mode_nx  = prec_mode;
          state_nx = in_last ? ST_HOLD : ST_ACCUM;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_nx  = sum_s;
          ovf_nx  = ovf_r | add_ovf_s;
          clip_nx = clip_r | clip_s;
          if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_nx = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_nx = cnt_r;
          end
          state_nx = in_last ? ST_HOLD : ST_ACCUM;
        end else begin
          state_nx = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register plus registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx;
      out_valid_r <= (state_nx == ST_HOLD);
      in_ready_r  <= (state_nx != ST_HOLD);
    end
  end

  // Accumulator, beat counter, sticky flags and latched mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= {ACC_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      ovf_r  <= 1'b0;
      clip_r <= 1'b0;
      mode_r <= 2'b00;
    end else begin
      acc_r  <= acc_nx;
      cnt_r  <= cnt_nx;
      ovf_r  <= ovf_nx;
      clip_r <= clip_nx;
      mode_r <= mode_nx;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_count = cnt_r;
  assign out_mode  = mode_r;
  assign out_ovf   = ovf_r;
  assign out_clip  = clip_r;

  st_acc_lvl2_chk #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_mode  (out_mode),
    .out_ovf   (out_ovf),
    .out_clip  (out_clip)
  );

endmodule

// Protocol checker: a held result never overlaps in_ready and stays stable until taken.
module st_acc_lvl2_chk #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [ACC_W-1:0] out_sum,
  input logic [CNT_W-1:0] out_count,
  input logic [1:0]       out_mode,
  input logic             out_ovf,
  input logic             out_clip
);

  logic                         held_r;
  logic [ACC_W+CNT_W+3:0]       snap_r;
  logic [ACC_W+CNT_W+3:0]       snap_s;

  assign snap_s = {out_sum, out_count, out_mode, out_ovf, out_clip};

  // Remember a stalled result and verify it unchanged one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_r <= 1'b0;
      snap_r <= {(ACC_W+CNT_W+4){1'b0}};
    end else begin
      assert (!(out_valid && in_ready));
      if (held_r) begin
        assert (out_valid && (snap_s == snap_r));
      end
      held_r <= out_valid && !out_ready;
      snap_r <= snap_s;
    end
  end

endmodule

// File: tb/tb_st_acc_lvl2.sv
// Randomized and directed bench for st_acc_lvl2 against a behavioural group-sum model.
module tb_st_acc_lvl2;

  localparam int ACC_W     = 40;
  localparam int MAX_SHIFT = 21;
  localparam int CNT_W     = 8;
  localparam longint MAXV  = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint MINV  = -(longint'(1) <<< (ACC_W-1));

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_mant;
  logic [5:0]       in_exp;
  logic             in_sign;
  logic             in_last;
  logic [1:0]       prec_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic [1:0]       out_mode;
  logic             out_ovf;
  logic             out_clip;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic signed [ACC_W-1:0] m_acc;
  int                      m_cnt;
  logic                    m_ovf;
  logic                    m_clip;
  logic [1:0]              m_mode;
  bit                      m_in_group;
  bit                      m_hold;

  st_acc_lvl2 #(.ACC_W(ACC_W), .MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .in_last   (in_last),
    .prec_mode (prec_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_mode  (out_mode),
    .out_ovf   (out_ovf),
    .out_clip  (out_clip)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_acc = '0; m_cnt = 0; m_ovf = 1'b0; m_clip = 1'b0; m_mode = 2'b00;
    m_in_group = 1'b0; m_hold = 1'b0;
  endtask

  task automatic model_beat(input logic [1:0] md, input logic sg, input logic [9:0] mt,
                            input logic [5:0] ex, input logic lst);
    longint op;
    longint t;
    int     sh;
    logic [1:0] use_md;
    bit     clp;
    use_md = m_in_group ? m_mode : md;
    if (use_md == 2'b11) begin
      op  = sg ? (longint'(mt) - 64'sd1024) : longint'(mt);
      clp = 1'b0;
    end else begin
      sh  = (int'(ex) > MAX_SHIFT) ? MAX_SHIFT : int'(ex);
      op  = longint'(mt) * (longint'(1) <<< sh);
      if (sg) op = -op;
      clp = (int'(ex) > MAX_SHIFT);
    end
    if (!m_in_group) begin
      m_acc = op[ACC_W-1:0]; m_cnt = 1; m_ovf = 1'b0; m_clip = clp; m_mode = md;
    end else begin
      t = longint'(m_acc) + op;
      if (t > MAXV || t < MINV) m_ovf = 1'b1;
      m_acc = t[ACC_W-1:0];
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      m_clip = m_clip | clp;
    end
    m_in_group = !lst;
    m_hold     = lst;
  endtask

  // Present one beat for one cycle; the model sees it only if it is accepted.
  task automatic drive_beat(input logic [1:0] md, input logic sg, input logic [9:0] mt,
                            input logic [5:0] ex, input logic lst);
    in_valid = 1'b1; prec_mode = md; in_sign = sg; in_mant = mt; in_exp = ex; in_last = lst;
    if (!m_hold) model_beat(md, sg, mt, ex, lst);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_hold = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    prec_mode = 2'b01; in_mant = 10'd7; in_exp = 6'd3; in_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_hs: valid/ready=%b required 01", {out_valid, in_ready});
    end
    checks++;
    if ({out_sum, out_count, out_mode, out_ovf, out_clip} !== {(ACC_W+CNT_W+4){1'b0}}) begin
      errors++; $display("FAIL reset_out: sum=%0d cnt=%0d mode=%b ovf=%b clip=%b required zeros",
                         out_sum, out_count, out_mode, out_ovf, out_clip);
    end
  endtask

  task automatic test_fp4();
    drive_beat(2'b11, 1'b1, 10'h3F0, 6'd9, 1'b0);
    drive_beat(2'b00, 1'b0, 10'd5, 6'd4, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out_sum) !== -40'sd11) begin
      errors++; $display("FAIL fp4_sum: valid=%b sum=%0d required valid=1 sum=-11", out_valid, $signed(out_sum));
    end
    checks++;
    if ({out_sum, out_count, out_mode, out_ovf, out_clip} !== {m_acc, CNT_W'(m_cnt), m_mode, m_ovf, m_clip}) begin
      errors++; $display("FAIL fp4_fields: sum=%0d cnt=%0d mode=%b ovf=%b clip=%b required %0d %0d %b %b %b",
                         $signed(out_sum), out_count, out_mode, out_ovf, out_clip, m_acc, m_cnt, m_mode, m_ovf, m_clip);
    end
    take_result();
  endtask

  task automatic test_magnitude();
    drive_beat(2'b00, 1'b0, 10'd100, 6'd3, 1'b0);
    drive_beat(2'b11, 1'b1, 10'd50, 6'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out_sum) !== 40'sd750 || out_clip !== 1'b0) begin
      errors++; $display("FAIL mag_sum: valid=%b sum=%0d clip=%b required 1 750 0", out_valid, $signed(out_sum), out_clip);
    end
    checks++;
    if ({out_sum, out_count, out_mode, out_ovf, out_clip} !== {m_acc, CNT_W'(m_cnt), m_mode, m_ovf, m_clip}) begin
      errors++; $display("FAIL mag_fields: sum=%0d cnt=%0d mode=%b required %0d %0d %b",
                         $signed(out_sum), out_count, out_mode, m_acc, m_cnt, m_mode);
    end
    take_result();
  endtask

  task automatic test_clip();
    drive_beat(2'b01, 1'b0, 10'd1, 6'd30, 1'b1);
    checks++;
    if ($signed(out_sum) !== 40'sd2097152 || out_clip !== 1'b1 || out_count !== 8'd1) begin
      errors++; $display("FAIL clip: sum=%0d clip=%b cnt=%0d required 2097152 1 1", $signed(out_sum), out_clip, out_count);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    drive_beat(2'b10, 1'b0, 10'd3, 6'd2, 1'b0);
    drive_beat(2'b10, 1'b1, 10'd1, 6'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_sum, out_count, out_mode, out_ovf, out_clip} !== {m_acc, CNT_W'(m_cnt), m_mode, m_ovf, m_clip}) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b ready=%b sum=%0d cnt=%0d required 1 0 %0d %0d",
                           i, out_valid, in_ready, $signed(out_sum), out_count, m_acc, m_cnt);
      end
      drive_beat(2'b00, 1'b0, 10'd999, 6'd5, 1'b1);
    end
    take_result();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release: valid/ready=%b required 01", {out_valid, in_ready});
    end
    drive_beat(2'b00, 1'b1, 10'd9, 6'd1, 1'b1);
    checks++;
    if ({out_sum, out_count, out_mode} !== {m_acc, CNT_W'(m_cnt), m_mode} || out_count !== 8'd1) begin
      errors++; $display("FAIL bp_next: sum=%0d cnt=%0d required %0d 1", $signed(out_sum), out_count, m_acc);
    end
    take_result();
  endtask

  task automatic test_overflow_saturation();
    for (int i = 0; i < 257; i++) drive_beat(2'b00, 1'b0, 10'd1023, 6'd21, (i == 256));
    checks++;
    if (out_ovf !== 1'b1 || out_count !== 8'd255 || out_sum !== m_acc) begin
      errors++; $display("FAIL ovf_sat: ovf=%b cnt=%0d sum=%0d required 1 255 %0d", out_ovf, out_count, $signed(out_sum), m_acc);
    end
    take_result();
  endtask

  task automatic test_reset_mid_group();
    for (int i = 0; i < 3; i++) drive_beat(2'b00, 1'b0, 10'd40 + 10'(i), 6'd2, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 8'd0) begin
      errors++; $display("FAIL rst_mid: valid=%b ready=%b cnt=%0d required 0 1 0", out_valid, in_ready, out_count);
    end
    drive_beat(2'b00, 1'b0, 10'd6, 6'd0, 1'b0);
    drive_beat(2'b00, 1'b0, 10'd7, 6'd1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || $signed(out_sum) !== 40'sd20 || out_count !== 8'd2) begin
      errors++; $display("FAIL rst_next: valid=%b sum=%0d cnt=%0d required 1 20 2", out_valid, $signed(out_sum), out_count);
    end
    out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_sum !== {ACC_W{1'b0}}) begin
      errors++; $display("FAIL rst_hold: valid=%b sum=%0d required 0 0", out_valid, $signed(out_sum));
    end
  endtask

  task automatic test_random();
    bit acc_b;
    bit cons_b;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (out_valid !== m_hold || in_ready !== !m_hold) begin
        errors++; $display("FAIL rnd_hs@%0d: valid=%b ready=%b required %b %b", cyc, out_valid, in_ready, m_hold, !m_hold);
      end
      if (m_hold) begin
        checks++;
        if ({out_sum, out_count, out_mode, out_ovf, out_clip} !== {m_acc, CNT_W'(m_cnt), m_mode, m_ovf, m_clip}) begin
          errors++; $display("FAIL rnd_res@%0d: sum=%0d cnt=%0d mode=%b ovf=%b clip=%b required %0d %0d %b %b %b",
                             cyc, $signed(out_sum), out_count, out_mode, out_ovf, out_clip, m_acc, m_cnt, m_mode, m_ovf, m_clip);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      prec_mode = 2'($urandom_range(0, 3));
      in_sign   = 1'($urandom_range(0, 1));
      in_mant   = 10'($urandom_range(0, 1023));
      in_exp    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(22, 63)) : 6'($urandom_range(0, 21));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc_b  = in_valid && !m_hold;
      cons_b = m_hold && out_ready;
      if (acc_b) model_beat(prec_mode, in_sign, in_mant, in_exp, in_last);
      if (cons_b) m_hold = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (m_hold) take_result();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fp4();
    test_magnitude();
    test_clip();
    test_backpressure();
    test_overflow_saturation();
    test_reset_mid_group();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
